// File: rtl/wide_add_sequencer.sv
// Wide (16*WORDS-bit) adder built by stepping an external 16-bit prefix adder one slice per clock.
// Define WADD_OVF_EN to add the registered signed-overflow output ovf.
module wide_add_sequencer #(
   parameter int unsigned WORDS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   op_a,
   input  logic [16*WORDS-1:0]   op_b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   sum,
   output logic                  cout,
`ifdef WADD_OVF_EN
   output logic                  ovf,
`endif
   output logic [15:0]           add_a,
   output logic [15:0]           add_b,
   output logic                  add_cin,
   output logic                  add_p0,
   input  logic [15:0]           add_sum
);

   localparam int unsigned W  = 16 * WORDS;
   localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [W-1:0]    a_q, b_q, part_q, part_d, sum_q;
   logic            carry_q, cout_q;
   logic [15:0]     a_sl, b_sl;
   logic            a15, b15, c15, carry_nxt, last, accept, run;
`ifdef WADD_OVF_EN
   logic            ovf_q, ovf_nxt;
`endif

   assign run    = (state_q == StRun);
   assign accept = in_valid && (state_q == StIdle);
   assign last   = (k_q == KW'(WORDS - 1));

   always_comb begin
      a_sl = a_q[16*k_q +: 16];
      b_sl = b_q[16*k_q +: 16];
   end

   // The adder has no carry-out: recover bit-15 carry-in from the sum, then rebuild the carry.
   assign a15       = a_sl[15];
   assign b15       = b_sl[15];
   assign c15       = add_sum[15] ^ a15 ^ b15;
   assign carry_nxt = (a15 & b15) | ((a15 | b15) & c15);
`ifdef WADD_OVF_EN
   assign ovf_nxt   = (a15 == b15) && (add_sum[15] != a15);
`endif

   always_comb begin
      part_d = part_q;
      part_d[16*k_q +: 16] = add_sum;
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StRun;
               k_d     = '0;
            end
         end
         StRun: begin
            if (last) state_d = StDone;
            else      k_d     = k_q + 1'b1;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // sum/cout only move on the edge that leaves RUN; slices accumulate in part_q meanwhile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef WADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else if (accept) begin
         a_q     <= op_a;
         b_q     <= op_b;
         carry_q <= cin;
      end else if (run) begin
         part_q  <= part_d;
         carry_q <= carry_nxt;
         if (last) begin
            sum_q  <= part_d;
            cout_q <= carry_nxt;
`ifdef WADD_OVF_EN
            ovf_q  <= ovf_nxt;
`endif
         end
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef WADD_OVF_EN
   assign ovf       = ovf_q;
`endif
   assign add_a     = run ? a_sl : 16'h0000;
   assign add_b     = run ? b_sl : 16'h0000;
   assign add_cin   = run ? carry_q : 1'b0;
   assign add_p0    = 1'b1;

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle operand sequencer that performs (16·WORDS)-bit additions by time-multiplexing the team's 16-bit parallel prefix adder, one 16-bit slice per clock, least-significant slice first. It sits directly upstream and downstream of that adder: it drives the adder's A/B/Cin/p_0 inputs, captures the adder's Sum output, and rebuilds the inter-slice carry. The adder exposes no carry-out, so this block derives it. Operands arrive and results leave on valid/ready handshakes.

## Interface
- WORDS, 2, number of 16-bit slices per operand; legal 1–8; operand width W = 16·WORDS
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operand request
- op_a  input  W  operand A
- op_b  input  W  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  registered result
- cout  output  1  registered carry out of the top slice
- ovf  output  1  signed overflow; present only with WADD_OVF_EN
- add_a  output  16  to adder A
- add_b  output  16  to adder B
- add_cin  output  1  to adder Cin
- add_p0  output  1  to adder p_0; constant 1
- add_sum  input  16  from adder Sum (combinational path, same cycle)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register op_a, op_b, cin into a_q, b_q, carry_q; slice counter k←0; go to RUN.
- RUN, slice k: add_a=a_q[16k+15:16k], add_b=b_q[16k+15:16k], add_cin=carry_q. At the clock edge: sum slice k←add_sum; carry_q←(a15&b15)|((a15|b15)&c15), where a15/b15 are the slice MSBs and c15=add_sum[15]^a15^b15. If k==WORDS-1: cout←new carry, go to DONE; else k←k+1.
- DONE: out_valid=1; sum/cout stable. On out_valid&&out_ready go to IDLE.
- in_ready=0 in RUN and DONE; in_valid is ignored there. No same-cycle DONE→accept bypass.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- Arithmetic is modulo 2^W; cout is the true carry out of bit W-1.
- Reset, including during RUN or DONE: state IDLE; sum=0, cout=0, ovf=0, out_valid=0, carry_q=0, k=0. in_ready reads 1 while rst_n is low. Any in-flight operation is discarded.

## Timing
- Request accepted at edge t → last slice captured at edge t+WORDS → out_valid high from t+WORDS until handshake.
- Minimum request-to-request interval: WORDS+2 cycles (accept, WORDS RUN cycles, DONE with out_ready=1).
- The adder path is combinational within a single RUN cycle; the adder's critical path plus carry derivation must fit one clk period.
- sum/cout/ovf change only on the edge that leaves RUN, or on reset.

## Configuration
- WADD_OVF_EN defined: port ovf exists. On the final slice, ovf←(a15 == b15) && (add_sum[15] != a15), i.e. two's-complement overflow of the W-bit add. ovf is held with sum; reset value 0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- WORDS=2, A=0x0000FFFF, B=0x00000001, cin=0 → sum=0x00010000, cout=0; out_valid exactly 2 edges after accept.
- A=0xFFFFFFFF, B=0x00000001, cin=0 → sum=0x00000000, cout=1; with WADD_OVF_EN, ovf=0.
- A=0x7FFFFFFF, B=0x00000001 → sum=0x80000000, cout=0, ovf=1; A=0, B=0, cin=1 → sum=0x00000001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/cout stable, out_valid=1, in_ready=0, new in_valid ignored; release → IDLE next edge, in_ready=1.
- Reset pulse (rst_n low) during RUN slice 1 → out_valid=0, sum=0, cout=0 immediately; the next request, 0x12345678+0x11111111, gives 0x23456789.
- WORDS=1: 0xFFFF+0x0001 → sum=0x0000, cout=1 after 1 RUN cycle; random 1000-vector sweep matching a behavioural (A+B+cin) model for WORDS=1,2,4.
